// File: rtl/serial_add_sequencer_pkg.sv
// serial_add_sequencer_pkg: shared byte width and FSM state encoding for the serial add/sub sequencer
package serial_add_sequencer_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;
endpackage

// File: rtl/serial_add_sequencer_if.sv
// serial_add_sequencer_if: request/response handshakes plus 8-bit adder bus; slave = sequencer, master = parent/bench
interface serial_add_sequencer_if
  import serial_add_sequencer_pkg::*;
#(
  parameter int NUM_BYTES = 4
);
  localparam int W = BYTE_W * NUM_BYTES;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [W-1:0]      a_i;
  logic [W-1:0]      b_i;
  logic              sub_i;
  logic              carry_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [W-1:0]      result_o;
  logic              carry_o;
  logic              overflow_o;
  logic              zero_o;
  logic [BYTE_W-1:0] add_a_o;
  logic [BYTE_W-1:0] add_b_o;
  logic              add_carry_o;
  logic [BYTE_W-1:0] add_sum_i;
  logic              add_carry_i;
  modport slave (
    input  req_valid_i, a_i, b_i, sub_i, carry_i, rsp_ready_i, add_sum_i, add_carry_i,
    output req_ready_o, rsp_valid_o, result_o, carry_o, overflow_o, zero_o, add_a_o, add_b_o, add_carry_o
  );
  modport master (
    output req_valid_i, a_i, b_i, sub_i, carry_i, rsp_ready_i, add_sum_i, add_carry_i,
    input  req_ready_o, rsp_valid_o, result_o, carry_o, overflow_o, zero_o, add_a_o, add_b_o, add_carry_o
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: wide add/sub one byte per cycle through an external 8-bit adder; ports clk_i, rst_i (sync high), bus (slave: req/rsp handshakes, operands, flags, adder a/b/cin out and sum/cout in)
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  serial_add_sequencer_if.slave bus
);
  localparam int IW = $clog2(NUM_BYTES);
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);
  seq_state_e state_q, state_d;
  logic [NUM_BYTES-1:0][BYTE_W-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, fin_q, fin_d, run;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      fin_q   <= fin_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    fin_d   = fin_q;
    if (state_q == IDLE && bus.req_valid_i) begin
      a_d     = bus.a_i;
      b_d     = bus.sub_i ? ~bus.b_i : bus.b_i;
      carry_d = bus.sub_i ^ bus.carry_i;
      idx_d   = '0;
      fin_d   = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      r_d[idx_q] = bus.add_sum_i;
      carry_d    = bus.add_carry_i;
      idx_d      = (idx_q == LAST) ? '0 : idx_q + IW'(1);
      fin_d      = idx_q == LAST;
      state_d    = (idx_q == LAST) ? DONE : RUN;
    end else if (state_q == DONE && bus.rsp_ready_i) begin
      state_d = IDLE;
    end
  end
  assign run             = state_q == RUN;
  assign bus.req_ready_o = state_q == IDLE;
  assign bus.rsp_valid_o = state_q == DONE;
  assign bus.add_a_o     = run ? a_q[idx_q] : '0;
  assign bus.add_b_o     = run ? b_q[idx_q] : '0;
  assign bus.add_carry_o = run & carry_q;
  assign bus.result_o    = r_q;
  assign bus.carry_o     = carry_q;
  // flags are qualified by fin_q so they read 0 out of reset and while a new operation is in flight
  assign bus.overflow_o  = fin_q & (a_q[NUM_BYTES-1][BYTE_W-1] == b_q[NUM_BYTES-1][BYTE_W-1])
                                 & (r_q[NUM_BYTES-1][BYTE_W-1] != a_q[NUM_BYTES-1][BYTE_W-1]);
  assign bus.zero_o      = fin_q & ~|r_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: randomized and directed check of serial_add_sequencer against an arithmetic reference model
module tb_serial_add_sequencer;
  localparam int N = 4;
  localparam int W = 8 * N;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  serial_add_sequencer_if #(.NUM_BYTES(N)) bus ();
  serial_add_sequencer #(.NUM_BYTES(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  assign {bus.add_carry_i, bus.add_sum_i} = {1'b0, bus.add_a_o} + {1'b0, bus.add_b_o} + {8'd0, bus.add_carry_o};
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask
  int ph = 0;
  bit started = 0;
  logic [W-1:0] ma = '0, mbe = '0, mres = '0;
  logic mcin = 1'b0, mc = 1'b0, mov = 1'b0, mhas = 1'b0;
  always @(posedge clk) begin
    longint sv, uv;
    started = 1;
    if (rst) begin
      ph = 0; mres = '0; mc = 1'b0; mov = 1'b0; mhas = 1'b0;
    end else if (ph == 0) begin
      if (bus.req_valid_i) begin
        if (bus.sub_i) begin
          sv = longint'($signed(bus.a_i)) - longint'($signed(bus.b_i)) - longint'(bus.carry_i);
          uv = longint'(bus.a_i) - longint'(bus.b_i) - longint'(bus.carry_i);
          mc = uv >= 0;
        end else begin
          sv = longint'($signed(bus.a_i)) + longint'($signed(bus.b_i)) + longint'(bus.carry_i);
          uv = longint'(bus.a_i) + longint'(bus.b_i) + longint'(bus.carry_i);
          mc = uv >= 64'sh1_0000_0000;
        end
        mres = sv[W-1:0];
        mov  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        ma   = bus.a_i;
        mbe  = bus.sub_i ? ~bus.b_i : bus.b_i;
        mcin = bus.sub_i ^ bus.carry_i;
        mhas = 1'b0;
        ph   = 1;
      end
    end else if (ph <= N) begin
      ph++;
      if (ph == N + 1) mhas = 1'b1;
    end else if (bus.rsp_ready_i) begin
      ph = 0;
    end
  end
  always @(negedge clk) begin
    logic [W:0] msk, part;
    int k;
    if (started) begin
      chk1("req_ready", bus.req_ready_o, ph == 0);
      chk1("rsp_valid", bus.rsp_valid_o, ph == N + 1);
      if (ph >= 1 && ph <= N) begin
        k = ph - 1;
        msk = ((W + 1)'(1) << (8 * k)) - (W + 1)'(1);
        part = ({1'b0, ma} & msk) + ({1'b0, mbe} & msk) + {{W{1'b0}}, mcin};
        chk("add_a", {24'd0, bus.add_a_o}, {24'd0, ma[8*k +: 8]});
        chk("add_b", {24'd0, bus.add_b_o}, {24'd0, mbe[8*k +: 8]});
        chk1("add_cin", bus.add_carry_o, part[8*k]);
      end else begin
        chk("add_ab_idle", {16'd0, bus.add_a_o, bus.add_b_o}, '0);
        chk1("add_cin_idle", bus.add_carry_o, 1'b0);
        chk("result", bus.result_o, mres);
        chk1("carry", bus.carry_o, mc);
        chk1("overflow", bus.overflow_o, mhas & mov);
        chk1("zero", bus.zero_o, mhas & (mres == '0));
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid_o && lat < 50) begin
      tick;
      lat++;
    end
    if (lat >= 50) begin
      bad++;
      total++;
      $display("FAIL rsp_timeout actual=none required=rsp_valid");
    end
  endtask
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c,
                    input bit early, input int hold);
    int lat;
    bus.a_i = a; bus.b_i = b; bus.sub_i = s; bus.carry_i = c;
    bus.req_valid_i = 1'b1;
    bus.rsp_ready_i = early;
    lat = 0;
    while (!bus.req_ready_o && lat < 50) begin
      tick;
      lat++;
    end
    tick;
    bus.req_valid_i = 1'b0;
    bus.a_i = $urandom; bus.b_i = $urandom; bus.sub_i = 1'($urandom); bus.carry_i = 1'($urandom);
    wait_rsp(lat);
    chk("latency", lat, N);
    if (!early || hold > 0) begin
      bus.rsp_ready_i = 1'b0;
      repeat (hold) tick;
      bus.rsp_ready_i = 1'b1;
    end
    tick;
    bus.rsp_ready_i = 1'b0;
  endtask
  task automatic expect_res(input logic [W-1:0] r, input logic c, input logic ov, input logic z);
    chk("lit_result", bus.result_o, r);
    chk1("lit_carry", bus.carry_o, c);
    chk1("lit_overflow", bus.overflow_o, ov);
    chk1("lit_zero", bus.zero_o, z);
  endtask
  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return '0;
      1: return '1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int lat;
    bus.req_valid_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.sub_i = 1'b0; bus.carry_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk1("rst_req_ready", bus.req_ready_o, 1'b1);
    chk1("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
    expect_res('0, 1'b0, 1'b0, 1'b0);
    op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 0);
    expect_res(32'h0000_0100, 1'b0, 1'b0, 1'b0);
    op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1);
    expect_res(32'h0000_0000, 1'b1, 1'b0, 1'b1);
    op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b1, 0);
    expect_res(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 2);
    expect_res(32'h0000_0002, 1'b1, 1'b0, 1'b0);
    op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 0);
    expect_res(32'h8000_0000, 1'b0, 1'b1, 1'b0);
    op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 0);
    expect_res(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    bus.a_i = 32'h1234_5678; bus.b_i = 32'h1111_1111; bus.sub_i = 1'b0; bus.carry_i = 1'b0;
    bus.req_valid_i = 1'b1;
    tick;
    bus.a_i = 32'h0000_000A; bus.b_i = 32'h0000_000B;
    wait_rsp(lat);
    repeat (5) begin
      chk1("bp_req_ready", bus.req_ready_o, 1'b0);
      chk1("bp_rsp_valid", bus.rsp_valid_o, 1'b1);
      chk("bp_result", bus.result_o, 32'h2345_6789);
      tick;
    end
    bus.rsp_ready_i = 1'b1;
    tick;
    bus.rsp_ready_i = 1'b0;
    chk1("no_bypass_idle", bus.req_ready_o, 1'b1);
    chk1("no_bypass_rsp", bus.rsp_valid_o, 1'b0);
    tick;
    bus.req_valid_i = 1'b0;
    chk1("second_accepted", bus.req_ready_o, 1'b0);
    wait_rsp(lat);
    chk("second_result", bus.result_o, 32'h0000_0015);
    bus.rsp_ready_i = 1'b1;
    tick;
    bus.rsp_ready_i = 1'b0;
    bus.a_i = 32'hDEAD_BEEF; bus.b_i = 32'h0102_0304; bus.req_valid_i = 1'b1;
    tick;
    bus.req_valid_i = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk1("abort_req_ready", bus.req_ready_o, 1'b1);
    chk1("abort_rsp_valid", bus.rsp_valid_o, 1'b0);
    chk("abort_add", {15'd0, bus.add_a_o, bus.add_b_o, bus.add_carry_o}, '0);
    expect_res('0, 1'b0, 1'b0, 1'b0);
    repeat (8) begin
      chk1("abort_no_rsp", bus.rsp_valid_o, 1'b0);
      tick;
    end
    for (int i = 0; i < 60; i++)
      op(pick(), pick(), 1'($urandom), 1'($urandom), ($urandom % 4) == 0, int'($urandom % 4));
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Multi-byte add/subtract sequencer that runs wide operands through the team's 8-bit Brent-Kung adder, one byte per cycle, LSB byte first. It sits directly around that adder. It drives the adder's a/b/carry-in inputs, consumes its sum/carry-out, and keeps the inter-byte carry in a register. Upstream and downstream use valid/ready handshakes; this gives wide arithmetic with a single 8-bit adder instance.

Parameters:
NUM_BYTES, 4, operand width in bytes (W = 8*NUM_BYTES); legal range 2..16

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset: synchronous, active-high; one clock; fixed
req_valid_i  input  1  request valid
req_ready_o  output  1  sequencer can accept a request
a_i  input  W  operand A
b_i  input  W  operand B
sub_i  input  1  0 = A+B+cin, 1 = A-B-borrow
carry_i  input  1  carry-in (add) / borrow-in (sub)
rsp_valid_o  output  1  result valid
rsp_ready_i  input  1  downstream accepts result
result_o  output  W  sum/difference
carry_o  output  1  raw final carry-out of MSB byte
overflow_o  output  1  signed overflow
zero_o  output  1  result_o == 0
add_a_o  output  8  byte to adder operand A
add_b_o  output  8  byte to adder operand B
add_carry_o  output  1  adder carry-in
add_sum_i  input  8  adder sum (combinational return)
add_carry_i  input  1  adder carry-out

Behaviour:
- FSM states IDLE, RUN, DONE. Reset: state IDLE, byte index 0; every output registered or forced to 0 (req_ready_o=1 is derived from IDLE).
- req_ready_o = (state==IDLE). rsp_valid_o = (state==DONE).
- Accept on an edge with req_valid_i & req_ready_o:
  - a_reg <= a_i.
  - b_reg <= sub_i ? ~b_i : b_i.
  - carry_reg <= sub_i ? ~carry_i : carry_i.
  - idx <= 0; go to RUN.
- RUN, combinational outputs: add_a_o = a_reg[8*idx +: 8], add_b_o = b_reg[8*idx +: 8], add_carry_o = carry_reg.
- RUN, on each edge: result_reg[8*idx +: 8] <= add_sum_i; carry_reg <= add_carry_i; idx <= idx+1. When idx==NUM_BYTES-1, go to DONE.
- Adder is purely combinational; the sum is captured on the same edge its inputs were driven.
- Outside RUN, add_a_o/add_b_o/add_carry_o = 0.
- Latency: accept on edge 0, bytes computed on edges 1..NUM_BYTES, rsp_valid_o high in the cycle after edge NUM_BYTES.
- Throughput: one operation per NUM_BYTES+2 cycles minimum. No bypass: IDLE lasts at least one cycle after a response handshake.
- DONE: result_o, carry_o, overflow_o, zero_o stay stable until rsp_valid_o & rsp_ready_i, then go to IDLE. Result registers keep their last value in IDLE.
- carry_o = carry_reg after the last byte. In sub mode, carry_o=1 means no borrow.
- overflow_o = (a_reg[W-1] == b_reg[W-1]) & (result_reg[W-1] != a_reg[W-1]), using the effective (inverted) b.
- zero_o = ~|result_reg.
- req_valid_i is ignored outside IDLE; a_i/b_i are sampled only on the accept edge.
- rsp_ready_i held high before DONE has no effect.
- Reset mid-RUN or mid-DONE: the operation is abandoned and no response is issued. Next cycle is IDLE with all outputs zero.
- Width rules: idx is $clog2(NUM_BYTES) bits and never exceeds NUM_BYTES-1. No arithmetic wider than 8 bits in this block.

Decomposition:
- Shared package: seq_state_e enum {IDLE, RUN, DONE}.
- Shared package: BYTE_W = 8 constant.
- No sub-module inside this block. The 8-bit Brent-Kung adder is instantiated alongside it at the parent level, wired port to port.
- Bench wraps both into a small test top.

Test Plan:
1. NUM_BYTES=4, add, a=0x000000FF, b=0x00000001, carry_i=0 -> result 0x00000100, carry 0, overflow 0, zero 0. rsp_valid_o rises exactly 4 edges after accept.
2. add, a=0xFFFFFFFF, b=0x00000001 -> result 0x00000000, carry 1, zero 1, overflow 0. The carry ripples through all four byte steps.
3. sub, a=0x00000005, b=0x00000007, carry_i=0 -> result 0xFFFFFFFE, carry 0 (borrow), overflow 0. Also sub, a=7, b=5 -> result 2, carry 1.
4. add, a=0x7FFFFFFF, b=0x00000001 -> result 0x80000000, overflow 1, carry 0. Also sub, a=0x80000000, b=1 -> result 0x7FFFFFFF, overflow 1.
5. Backpressure: hold rsp_ready_i=0 for 5 cycles in DONE -> result/flags stable and req_ready_o=0. A second req_valid_i is not accepted until the cycle after the response handshake.
6. Reset after 2 RUN cycles -> next cycle: IDLE, req_ready_o=1, rsp_valid_o=0, add_* = 0, result_o=0. No response is emitted for the aborted operation.
